// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: start/stop sequencer and valid/ready ratio loader for the programmable divider.
// Optional CLK_DIV_BURST_EN: auto-stop after i_burst_len o_clk rises, signalled by o_done.
module clk_div_ctrl #(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned RESET_DIV = 25000,
  parameter int unsigned BURST_W   = 8
) (
  input  logic               i_clk_FPGA,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_cfg_valid,
  input  logic [DIV_W-1:0]   i_cfg_div,
  output logic               o_cfg_ready,
  input  logic [BURST_W-1:0] i_burst_len,
  output logic               o_clk,
  output logic               o_tick,
  output logic               o_busy,
  output logic               o_cfg_err,
  output logic               o_done
);

  localparam logic [DIV_W-1:0] ResetDiv = DIV_W'(RESET_DIV);
  localparam logic [DIV_W-1:0] DivOne   = DIV_W'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             shadow_vld_q, shadow_vld_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic             at_end, fall, go, burst_hit, to_idle;

  assign at_end = (cnt_q == div_q - DivOne);
  assign fall   = (state_q != StIdle) && at_end && clk_q;
  assign go     = i_start && !i_stop;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    clk_d        = clk_q;
    tick_d       = 1'b0;
    err_d        = 1'b0;
    to_idle      = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (shadow_vld_q) begin
          div_d        = shadow_q;
          shadow_vld_d = 1'b0;
        end
        if (go) begin
          state_d = StRun;
        end
      end
      StRun, StDrain: begin
        if (at_end) begin
          cnt_d  = '0;
          clk_d  = !clk_q;
          tick_d = !clk_q;
        end else begin
          cnt_d = cnt_q + DivOne;
        end
        // The high phase in flight finishes on the old ratio; the new one starts with the low phase.
        if (fall && shadow_vld_q) begin
          div_d        = shadow_q;
          shadow_vld_d = 1'b0;
        end
        if (state_q == StDrain) begin
          to_idle = fall;
        end else if (i_stop || burst_hit) begin
          if (!clk_q && (cnt_q == '0) && !burst_hit) begin
            // Sitting on a period boundary: nothing to finish, stop without emitting an edge.
            to_idle = 1'b1;
            cnt_d   = '0;
            clk_d   = 1'b0;
            tick_d  = 1'b0;
          end else if (fall) begin
            to_idle = 1'b1;
          end else begin
            state_d = StDrain;
          end
        end
        if (to_idle) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (i_cfg_valid && !shadow_vld_q) begin
      if (i_cfg_div != '0) begin
        shadow_d     = i_cfg_div;
        shadow_vld_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk_FPGA or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      div_q        <= ResetDiv;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      clk_q        <= 1'b0;
      tick_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      clk_q        <= clk_d;
      tick_q       <= tick_d;
      err_q        <= err_d;
    end
  end

`ifdef CLK_DIV_BURST_EN
  localparam logic [BURST_W-1:0] BurstOne = BURST_W'(1);

  logic [BURST_W-1:0] blen_q, blen_d;
  logic [BURST_W-1:0] bcnt_q, bcnt_d;
  logic               done_q, done_d;
  logic               rise;

  assign rise      = (state_q != StIdle) && at_end && !clk_q;
  // The final rise of a burst is treated exactly like a stop sampled on that edge.
  assign burst_hit = rise && (blen_q != '0) && (bcnt_q == blen_q - BurstOne);

  always_comb begin
    blen_d = blen_q;
    bcnt_d = bcnt_q;
    done_d = to_idle && (blen_q != '0);
    if (state_q == StIdle) begin
      if (go) begin
        blen_d = i_burst_len;
        bcnt_d = '0;
      end
    end else if (rise) begin
      bcnt_d = bcnt_q + BurstOne;
    end
  end

  always_ff @(posedge i_clk_FPGA or negedge i_reset) begin
    if (!i_reset) begin
      blen_q <= '0;
      bcnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      blen_q <= blen_d;
      bcnt_q <= bcnt_d;
      done_q <= done_d;
    end
  end

  assign o_done = done_q;
`else
  logic unused_burst_len;
  assign unused_burst_len = ^i_burst_len;
  assign burst_hit        = 1'b0;
  assign o_done           = 1'b0;
`endif

  assign o_clk       = clk_q;
  assign o_tick      = tick_q;
  assign o_busy      = (state_q != StIdle);
  assign o_cfg_ready = !shadow_vld_q;
  assign o_cfg_err   = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: phase-countdown reference model checked every cycle, plus directed
// literal expectations on rise timing, phase lengths, handshake, stop and reset behaviour.
module tb_clk_div_ctrl;

  localparam int RD = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, cfg_valid;
  logic [15:0] cfg_div;
  logic [7:0]  burst_len;
  logic        o_cfg_ready, o_clk, o_tick, o_busy, o_cfg_err, o_done;

  int n_checks = 0;
  int n_errors = 0;

  clk_div_ctrl #(
    .DIV_W    (16),
    .RESET_DIV(RD),
    .BURST_W  (8)
  ) dut (
    .i_clk_FPGA (clk),
    .i_reset    (rst_n),
    .i_start    (start),
    .i_stop     (stop),
    .i_cfg_valid(cfg_valid),
    .i_cfg_div  (cfg_div),
    .o_cfg_ready(o_cfg_ready),
    .i_burst_len(burst_len),
    .o_clk      (o_clk),
    .o_tick     (o_tick),
    .o_busy     (o_busy),
    .o_cfg_err  (o_cfg_err),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a phase lasts m_div cycles; m_left is the cycles left in the current phase.
  int m_state;  // 0 idle, 1 running, 2 stopping
  bit m_level, m_pend, m_tick, m_err, m_done;
  int m_left, m_div, m_pend_div, m_blen, m_bcnt;

  task automatic model_reset();
    m_state = 0; m_level = 0; m_left = 0; m_div = RD; m_pend = 0; m_pend_div = 0;
    m_tick = 0; m_err = 0; m_done = 0; m_blen = 0; m_bcnt = 0;
  endtask

  task automatic model_step();
    bit old_pend, bhit, leave;
    if (!rst_n) begin
      model_reset();
      return;
    end
    old_pend = m_pend;
    m_tick = 0; m_err = 0; m_done = 0; leave = 0; bhit = 0;
    if (m_state == 0) begin
      if (m_pend) begin
        m_div = m_pend_div; m_pend = 0;
      end
      if (start && !stop) begin
        m_state = 1; m_level = 0; m_left = m_div; m_bcnt = 0; m_blen = int'(burst_len);
      end
    end else begin
`ifdef CLK_DIV_BURST_EN
      bhit = (m_state == 1) && !m_level && (m_left == 1) && (m_blen != 0) && (m_bcnt + 1 == m_blen);
`endif
      if (m_state == 1 && stop && !bhit && !m_level && m_left == m_div) begin
        leave = 1;
      end else if (m_left == 1) begin
        if (m_level) begin
          m_level = 0;
          if (m_pend) begin
            m_div = m_pend_div; m_pend = 0;
          end
          m_left = m_div;
          if (m_state == 2 || stop) leave = 1;
        end else begin
          m_level = 1; m_tick = 1; m_left = m_div; m_bcnt++;
          if (m_state == 1 && (stop || bhit)) m_state = 2;
        end
      end else begin
        m_left--;
        if (m_state == 1 && stop) m_state = 2;
      end
      if (leave) begin
        m_state = 0; m_level = 0;
`ifdef CLK_DIV_BURST_EN
        m_done = (m_blen != 0);
`endif
      end
    end
    if (cfg_valid && !old_pend) begin
      if (cfg_div != 16'd0) begin
        m_pend = 1; m_pend_div = int'(cfg_div);
      end else begin
        m_err = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    check_bit("o_clk", o_clk, m_level);
    check_bit("o_tick", o_tick, m_tick);
    check_bit("o_busy", o_busy, m_state != 0);
    check_bit("o_cfg_ready", o_cfg_ready, !m_pend);
    check_bit("o_cfg_err", o_cfg_err, m_err);
    check_bit("o_done", o_done, m_done);
  end

  task automatic wait_rise();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(o_clk === 1'b1 && o_tick === 1'b1) && k < 200);
    check_bit("rise_seen", o_clk && o_tick, 1'b1);
  endtask

  task automatic phase_len(input logic lvl, output int n);
    n = 0;
    while (o_clk === lvl && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output int ticks, output int dones);
    int k = 0;
    ticks = 0; dones = 0;
    while (k < 300) begin
      @(negedge clk);
      k++;
      if (o_tick) ticks++;
      if (o_done) dones++;
      if (!o_busy) break;
    end
    check_bit("idle_reached", o_busy, 1'b0);
  endtask

  task automatic offer(input logic [15:0] d);
    cfg_valid = 1'b1; cfg_div = d;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ticks, dones;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = '0; burst_len = '0;
    #1;
    check_bit("rst_clk", o_clk, 1'b0);
    check_bit("rst_tick", o_tick, 1'b0);
    check_bit("rst_busy", o_busy, 1'b0);
    check_bit("rst_ready", o_cfg_ready, 1'b1);
    check_bit("rst_err", o_cfg_err, 1'b0);
    check_bit("rst_done", o_done, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // div=3 loaded in IDLE: ready low one cycle, then applied
    offer(16'd3);
    check_bit("ready_low_after_accept", o_cfg_ready, 1'b0);
    @(negedge clk);
    check_bit("ready_back_in_idle", o_cfg_ready, 1'b1);

    // start sampled on edge S: rise on S+3, fall on S+6, next rise on S+9
    pulse_start();
    check_bit("busy_after_start", o_busy, 1'b1);
    repeat (2) @(negedge clk);
    check_bit("low_before_first_rise", o_clk, 1'b0);
    @(negedge clk);
    check_bit("first_rise_clk", o_clk, 1'b1);
    check_bit("first_rise_tick", o_tick, 1'b1);
    @(negedge clk);
    check_bit("tick_one_cycle", o_tick, 1'b0);
    repeat (2) @(negedge clk);
    check_bit("first_fall", o_clk, 1'b0);
    repeat (3) @(negedge clk);
    check_bit("second_rise_tick", o_tick, 1'b1);

    // div=5 offered in the first cycle of a high phase
    cfg_valid = 1'b1; cfg_div = 16'd5;
    @(negedge clk);
    cfg_valid = 1'b0;
    check_bit("ready_low_pending", o_cfg_ready, 1'b0);
    phase_len(1'b1, n);
    check_int("old_high_len", n + 1, 3);
    check_bit("ready_after_fall", o_cfg_ready, 1'b1);
    phase_len(1'b0, n);
    check_int("new_low_len", n, 5);
    phase_len(1'b1, n);
    check_int("new_high_len", n, 5);

    // move to div=4, then offer the illegal zero ratio
    offer(16'd4);
    wait_rise();
    wait_rise();
    offer(16'd0);
    check_bit("zero_err_pulse", o_cfg_err, 1'b1);
    check_bit("zero_ready_stays", o_cfg_ready, 1'b1);
    @(negedge clk);
    check_bit("zero_err_once", o_cfg_err, 1'b0);
    wait_rise();
    phase_len(1'b1, n);
    check_int("div4_high_len", n, 4);
    phase_len(1'b0, n);
    check_int("div4_low_len", n, 4);

    // stop in the first high cycle: three more high cycles, then fall into IDLE
    pulse_stop();
    phase_len(1'b1, n);
    check_int("drain_high_left", n, 3);
    check_bit("drain_idle_busy", o_busy, 1'b0);
    check_bit("drain_idle_clk", o_clk, 1'b0);

    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check_bit("start_stop_together", o_busy, 1'b0);

    // stop on the boundary right after start, and right after a fall
    pulse_start();
    pulse_stop();
    check_bit("boundary_stop_at_start", o_busy, 1'b0);
    pulse_start();
    wait_rise();
    phase_len(1'b1, n);
    pulse_stop();
    check_bit("boundary_stop_after_fall", o_busy, 1'b0);
    check_bit("boundary_stop_clk", o_clk, 1'b0);

    // stop mid low phase: drains through one full high phase
    pulse_start();
    @(negedge clk);
    pulse_stop();
    wait_idle(ticks, dones);
    check_int("drain_through_rise_ticks", ticks, 1);

    // reset mid high phase with a pending ratio
    pulse_start();
    wait_rise();
    offer(16'd2);
    check_bit("pending_before_reset", o_cfg_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check_bit("midrst_clk", o_clk, 1'b0);
    check_bit("midrst_tick", o_tick, 1'b0);
    check_bit("midrst_busy", o_busy, 1'b0);
    check_bit("midrst_ready", o_cfg_ready, 1'b1);
    check_bit("midrst_err", o_cfg_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    wait_rise();
    phase_len(1'b1, n);
    check_int("resetdiv_high_len", n, RD);
    phase_len(1'b0, n);
    check_int("resetdiv_low_len", n, RD);
    pulse_stop();
    wait_idle(ticks, dones);

`ifdef CLK_DIV_BURST_EN
    offer(16'd2);
    @(negedge clk);
    burst_len = 8'd4;
    pulse_start();
    wait_idle(ticks, dones);
    check_int("burst_ticks", ticks, 4);
    check_int("burst_done_pulses", dones, 1);
    check_bit("burst_done_at_idle", o_done, 1'b1);
    burst_len = 8'd0;
    pulse_start();
    repeat (40) @(negedge clk);
    check_bit("freerun_still_busy", o_busy, 1'b1);
    pulse_stop();
    wait_idle(ticks, dones);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
